// File: rtl/alu_src_b_stage.sv
// alu_src_b_stage
// ---------------
// Registered operand-B selector for the multicycle datapath. On each accepted
// request the select code picks B, the PC-increment constant, or one of the
// extended/shifted immediate forms. The result and an illegal-select flag are
// stored in a 2-entry skid buffer, so the ALU can stall without losing an
// operand that has already been selected.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   upstream offers a selection this cycle
//   in_ready   stage can accept (registered, from occupancy)
//   alu_src_b  operand select code (0..7)
//   b_reg      B register value
//   imm        raw immediate field
//   flush      discard all buffered operands
//   out_valid  operand_b holds a valid entry
//   out_ready  ALU consumes the head entry this cycle
//   operand_b  head entry value (0 when empty)
//   sel_error  head entry came from an illegal select code

module alu_src_b_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CONST_INC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           alu_src_b,
  input  logic [WIDTH-1:0]     b_reg,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     operand_b,
  output logic                 sel_error
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Returns {error, value} for one select code. Illegal codes give value 0
  // so a bad select never leaks a stale operand into the ALU.
  function automatic logic [WIDTH:0] decode_operand(
    input logic [2:0]           sel,
    input logic [WIDTH-1:0]     b_val,
    input logic [IMM_WIDTH-1:0] imm_val
  );
    logic [WIDTH-1:0] sext;
    logic [WIDTH-1:0] zext;
    logic [WIDTH-1:0] upper;
    logic [WIDTH:0]   res;
    sext  = {{(WIDTH-IMM_WIDTH){imm_val[IMM_WIDTH-1]}}, imm_val};
    zext  = {{(WIDTH-IMM_WIDTH){1'b0}}, imm_val};
    upper = {imm_val, {(WIDTH-IMM_WIDTH){1'b0}}};
    case (sel)
      3'd0:    res = {1'b0, b_val};
      3'd1:    res = {1'b0, WIDTH'(CONST_INC)};
      3'd2:    res = {1'b0, sext};
      // Branch offset: bits pushed past the top are simply dropped.
      3'd3:    res = {1'b0, sext[WIDTH-3:0], 2'b00};
      3'd4:    res = {1'b0, zext};
      3'd5:    res = {1'b0, upper};
      default: res = {1'b1, {WIDTH{1'b0}}};
    endcase
    return res;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             head_err_r;
  logic             head_err_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             skid_err_r;
  logic             skid_err_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH:0]   dec_s;
  logic [WIDTH-1:0] dec_val_s;
  logic             dec_err_s;
  logic             accept_s;
  logic             pop_s;

  assign dec_s     = decode_operand(alu_src_b, b_reg, imm);
  assign dec_val_s = dec_s[WIDTH-1:0];
  assign dec_err_s = dec_s[WIDTH];

  // Handshakes use only registered ready/valid, so there is no path from
  // out_ready to in_ready or from in_* to out_*.
  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // Occupancy next-state and data movement through head and skid slots.
  always_comb begin
    state_nxt_s    = state_r;
    head_nxt_s     = head_r;
    head_err_nxt_s = head_err_r;
    skid_nxt_s     = skid_r;
    skid_err_nxt_s = skid_err_r;
    if (flush) begin
      // Any pop this cycle is a normal consume; an offered entry is dropped.
      state_nxt_s    = EMPTY;
      head_nxt_s     = {WIDTH{1'b0}};
      head_err_nxt_s = 1'b0;
      skid_nxt_s     = {WIDTH{1'b0}};
      skid_err_nxt_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s    = ONE;
            head_nxt_s     = dec_val_s;
            head_err_nxt_s = dec_err_s;
          end else begin
            state_nxt_s    = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            state_nxt_s    = ONE;
            head_nxt_s     = dec_val_s;
            head_err_nxt_s = dec_err_s;
          end else if (accept_s) begin
            state_nxt_s    = TWO;
            skid_nxt_s     = dec_val_s;
            skid_err_nxt_s = dec_err_s;
          end else if (pop_s) begin
            state_nxt_s    = EMPTY;
            head_nxt_s     = {WIDTH{1'b0}};
            head_err_nxt_s = 1'b0;
          end else begin
            state_nxt_s    = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            state_nxt_s    = ONE;
            head_nxt_s     = skid_r;
            head_err_nxt_s = skid_err_r;
            skid_nxt_s     = {WIDTH{1'b0}};
            skid_err_nxt_s = 1'b0;
          end else begin
            state_nxt_s    = TWO;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          state_nxt_s    = EMPTY;
          head_nxt_s     = {WIDTH{1'b0}};
          head_err_nxt_s = 1'b0;
          skid_nxt_s     = {WIDTH{1'b0}};
          skid_err_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, data and handshake registers; ready/valid are precomputed from
  // the next state so they are plain flops at the ports.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= EMPTY;
      head_r      <= {WIDTH{1'b0}};
      head_err_r  <= 1'b0;
      skid_r      <= {WIDTH{1'b0}};
      skid_err_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_r      <= head_nxt_s;
      head_err_r  <= head_err_nxt_s;
      skid_r      <= skid_nxt_s;
      skid_err_r  <= skid_err_nxt_s;
      in_ready_r  <= (state_nxt_s != TWO);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign operand_b = head_r;
  assign sel_error = head_err_r;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed testbench for alu_src_b_stage: a default 32-bit instance and a
// 64-bit instance with CONST_INC=8. Expected values are hand-computed.

module tb_alu_src_b_stage;

  logic        clock;
  logic        reset;

  // 32-bit instance signals
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_src_b;
  logic [31:0] b_reg;
  logic [15:0] imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_b;
  logic        sel_error;

  // 64-bit instance signals
  logic        in_valid64;
  logic        in_ready64;
  logic [2:0]  alu_src_b64;
  logic [63:0] b_reg64;
  logic [15:0] imm64;
  logic        flush64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] operand_b64;
  logic        sel_error64;

  int n_cmp;
  int n_err;

  alu_src_b_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_src_b (alu_src_b),
    .b_reg     (b_reg),
    .imm       (imm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand_b (operand_b),
    .sel_error (sel_error)
  );

  alu_src_b_stage #(.WIDTH(64), .IMM_WIDTH(16), .CONST_INC(8)) dut64 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .alu_src_b (alu_src_b64),
    .b_reg     (b_reg64),
    .imm       (imm64),
    .flush     (flush64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .operand_b (operand_b64),
    .sel_error (sel_error64)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle, so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] val,
                           input logic err, input logic rdy);
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check_eq({tag, ".operand_b"}, 64'(operand_b), 64'(val));
    check_eq({tag, ".sel_error"}, 64'(sel_error), 64'(err));
    check_eq({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  logic [31:0] exp_sel [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    in_valid = 1'b0; alu_src_b = 3'd0; b_reg = 32'h0; imm = 16'h0;
    flush = 1'b0; out_ready = 1'b0;
    in_valid64 = 1'b0; alu_src_b64 = 3'd0; b_reg64 = 64'h0; imm64 = 16'h0;
    flush64 = 1'b0; out_ready64 = 1'b0;

    // Reset state
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("reset64.out_valid", 64'(out_valid64), 64'h0);
    reset = 1'b1;
    tick();
    check_out("idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // Back-to-back legal selects, one result per cycle
    exp_sel[0] = 32'h12345678;
    exp_sel[1] = 32'h00000004;
    exp_sel[2] = 32'hFFFF8001;
    exp_sel[3] = 32'hFFFE0004;
    exp_sel[4] = 32'h00008001;
    exp_sel[5] = 32'h80010000;
    b_reg = 32'h12345678; imm = 16'h8001; out_ready = 1'b1; in_valid = 1'b1;
    for (int s = 0; s < 6; s++) begin
      alu_src_b = 3'(s);
      tick();
      check_out($sformatf("sel%0d", s), 1'b1, exp_sel[s], 1'b0, 1'b1);
    end

    // Illegal selects, then recovery on a legal one
    alu_src_b = 3'd6; tick();
    check_out("sel6", 1'b1, 32'h0, 1'b1, 1'b1);
    alu_src_b = 3'd7; tick();
    check_out("sel7", 1'b1, 32'h0, 1'b1, 1'b1);
    alu_src_b = 3'd0; tick();
    check_out("sel0_after_err", 1'b1, 32'h12345678, 1'b0, 1'b1);
    in_valid = 1'b0; tick();
    check_out("drain", 1'b0, 32'h0, 1'b0, 1'b1);

    // Backpressure: two accepts fill the buffer, third offer ignored
    out_ready = 1'b0; in_valid = 1'b1; imm = 16'h0010;
    alu_src_b = 3'd1; tick();
    check_out("bp_first", 1'b1, 32'h4, 1'b0, 1'b1);
    alu_src_b = 3'd2; tick();
    check_out("bp_full", 1'b1, 32'h4, 1'b0, 1'b0);
    alu_src_b = 3'd0; b_reg = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("bp_stall%0d", i), 1'b1, 32'h4, 1'b0, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_out("bp_second", 1'b1, 32'h10, 1'b0, 1'b1);
    tick();
    check_out("bp_empty", 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check_out("bp_no_third", 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush while full, with an accept offered in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1; imm = 16'h0010;
    alu_src_b = 3'd1; tick();
    alu_src_b = 3'd2; tick();
    check_out("fl_full", 1'b1, 32'h4, 1'b0, 1'b0);
    alu_src_b = 3'd0; b_reg = 32'hA5A5A5A5; flush = 1'b1;
    tick();
    check_out("fl_after", 1'b0, 32'h0, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_out("fl_no_ghost", 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of operation while full
    out_ready = 1'b0; in_valid = 1'b1;
    alu_src_b = 3'd4; imm = 16'h1234; tick();
    alu_src_b = 3'd5; tick();
    check_out("rst_full", 1'b1, 32'h00001234, 1'b0, 1'b0);
    reset = 1'b0; alu_src_b = 3'd0; b_reg = 32'h11111111;
    tick();
    check_out("rst_mid", 1'b0, 32'h0, 1'b0, 1'b1);
    reset = 1'b1; b_reg = 32'hCAFEBABE; out_ready = 1'b1;
    tick();
    check_out("rst_first", 1'b1, 32'hCAFEBABE, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    check_out("rst_drain", 1'b0, 32'h0, 1'b0, 1'b1);

    // 64-bit instance with CONST_INC=8
    imm64 = 16'hFFFF; out_ready64 = 1'b1; in_valid64 = 1'b1;
    alu_src_b64 = 3'd2; tick();
    check_eq("w64_sel2", operand_b64, 64'hFFFFFFFFFFFFFFFF);
    check_eq("w64_sel2.valid", 64'(out_valid64), 64'h1);
    alu_src_b64 = 3'd3; tick();
    check_eq("w64_sel3", operand_b64, 64'hFFFFFFFFFFFFFFFC);
    alu_src_b64 = 3'd5; tick();
    check_eq("w64_sel5", operand_b64, 64'hFFFF000000000000);
    alu_src_b64 = 3'd1; tick();
    check_eq("w64_sel1", operand_b64, 64'h8);
    check_eq("w64_sel1.err", 64'(sel_error64), 64'h0);
    in_valid64 = 1'b0; tick();
    check_eq("w64_drain", 64'(out_valid64), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_src_b_stage.md
Name: alu_src_b_stage

Overview:
- Registered, parametrised successor to the combinational ALU operand-B selector in the multicycle datapath.
- Computes operand B from the B register, an increment constant, or one of several extended/shifted immediates.
- Buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides, so the control unit can stall the ALU without losing a selected operand.
- Flags illegal select codes instead of silently holding a stale value.

Parameters:
- WIDTH, 32, datapath width of B and operand_b.
- IMM_WIDTH, 16, width of the raw immediate field; must be less than WIDTH.
- CONST_INC, 4, constant driven for select 1 (PC increment).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clock rising edge)
- in_valid  input  1  upstream offers a selection this cycle
- in_ready  output  1  stage can accept; registered, derived from occupancy
- alu_src_b  input  3  operand select code
- b_reg  input  WIDTH  B register value
- imm  input  IMM_WIDTH  raw immediate field
- flush  input  1  discard all buffered operands
- out_valid  output  1  operand_b holds a valid entry
- out_ready  input  1  ALU consumes the head entry this cycle
- operand_b  output  WIDTH  head entry value
- sel_error  output  1  head entry was produced from an illegal select

Behaviour:
- Select decode, combinational on accept; only the computed value and error bit are stored:
  - 0: b_reg
  - 1: CONST_INC zero-extended to WIDTH
  - 2: sign-extended imm
  - 3: sign-extended imm shifted left 2 (branch offset); bits shifted out above WIDTH are dropped
  - 4: zero-extended imm
  - 5: imm placed in the upper IMM_WIDTH bits, low bits 0 (upper-immediate)
  - 6 and 7: value 0, error bit 1
  - The error bit is 0 for codes 0-5.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Entries leave in acceptance order.
- Occupancy FSM, states EMPTY / ONE / TWO:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - EMPTY: accept -> ONE (entry visible the next cycle, latency 1); otherwise stay.
  - ONE, accept and pop -> ONE with the new entry at head (throughput 1/cycle).
  - ONE, accept only -> TWO (new entry goes to the skid slot).
  - ONE, pop only -> EMPTY.
  - ONE, neither -> hold.
  - TWO: accept impossible (in_ready = 0). Pop -> ONE, skid moves to head. No pop -> hold.
- Head stability: while out_valid && !out_ready, operand_b and sel_error remain constant. Inputs changing while in_ready = 0 or in_valid = 0 have no effect.
- Flush:
  - Next state is EMPTY.
  - An accept offered in the flush cycle is discarded.
  - A pop in the flush cycle is still a legal consume of the current head.
  - in_ready = 1 the cycle after a flush.
- Reset (reset = 0 at a clock edge):
  - State EMPTY, in_ready = 1, out_valid = 0, operand_b = 0, sel_error = 0, skid slot = 0.
  - Reset overrides flush and accept, and applies mid-operation regardless of occupancy.
- operand_b and sel_error read 0 whenever the FSM is EMPTY. Data registers are cleared on pop-to-empty and on flush.
- All outputs are registered; there is no combinational path from in_* to out_*, or from out_ready to in_ready.

Test Plan:
- Reset, then sel 0..5 back-to-back with b_reg=0x12345678, imm=0x8001, out_ready=1:
  - After 1-cycle latency: 0x12345678, 0x00000004, 0xFFFF8001, 0xFFFE0004, 0x00008001, 0x80010000.
  - sel_error = 0, one result per cycle.
- sel 6 then 7 with out_ready=1 -> operand_b = 0, sel_error = 1 for each; next legal sel 0 -> sel_error = 0.
- Backpressure:
  - Hold out_ready=0 and offer sel 1 then sel 2 (imm=0x0010). in_ready drops to 0 after the second accept; a third offer (sel 0) is ignored.
  - Head stays 0x4 across 5 stall cycles.
  - Release out_ready -> 0x4, then 0x10, then empty, with no third value.
- Flush with TWO entries while in_valid=1 and sel 0 is offered:
  - Next cycle out_valid = 0, in_ready = 1, operand_b = 0.
  - The offered entry never appears.
- Reset mid-operation: reset = 0 while TWO entries are held -> next edge out_valid = 0, in_ready = 1, outputs 0; after reset, the first accept appears with latency 1.
- Parameter sweep WIDTH=64, IMM_WIDTH=16, CONST_INC=8, imm=0xFFFF:
  - sel 2 -> 0xFFFFFFFFFFFFFFFF
  - sel 3 -> 0xFFFFFFFFFFFFFFFC
  - sel 5 -> 0xFFFF000000000000
  - sel 1 -> 0x8
